// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
// Memory-stage responder that sits between EX/MEM and MEM/WB. It decodes
// READ_WRITE, runs a word-wide handshake with the backing data memory, steers
// store lanes, extracts and extends load data, and stalls the pipeline via
// BUSYWAIT while an access is outstanding.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW skip memory, go IDLE->DONE and
//               pulse MISALIGNED with READ_DATA cleared.
//   undefined : misaligned low address bits are forced to natural alignment
//               and MISALIGNED is tied low.
//
// Handshake: the memory sees a request while MEM_READ or MEM_WRITE is high;
// address, data and byte enables are held stable for that whole time, and the
// access completes on the first rising edge in ACCESS where MEM_READY is high.
// The pipeline side is frozen while BUSYWAIT is high and captures the next
// request on the DONE->IDLE edge.
module data_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [29:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTEEN,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_READY,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0]  SZ_BYTE      = 2'd0;
    localparam logic [1:0]  SZ_HALF      = 2'd1;
    localparam logic [1:0]  SZ_WORD      = 2'd2;
    // Abort on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    logic        req_valid;
    logic        req_load;
    logic        req_signed;
    logic        req_trap;
    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    logic        op_load;
    logic        op_signed;
    logic [1:0]  op_size;
    logic [1:0]  op_off;

    logic [15:0] wait_cnt;
    logic        timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    // Decode the request code into access kind, size and signedness.
    always_comb begin
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_signed = 1'b0;
        req_size   = SZ_WORD;
        case (READ_WRITE)
            4'b1000: begin req_valid = 1'b1; req_load = 1'b1; req_signed = 1'b1; req_size = SZ_BYTE; end
            4'b1001: begin req_valid = 1'b1; req_load = 1'b1; req_signed = 1'b1; req_size = SZ_HALF; end
            4'b1010: begin req_valid = 1'b1; req_load = 1'b1; req_size = SZ_WORD; end
            4'b1100: begin req_valid = 1'b1; req_load = 1'b1; req_size = SZ_BYTE; end
            4'b1101: begin req_valid = 1'b1; req_load = 1'b1; req_size = SZ_HALF; end
            4'b0001: begin req_valid = 1'b1; req_size = SZ_BYTE; end
            4'b0010: begin req_valid = 1'b1; req_size = SZ_HALF; end
            4'b0011: begin req_valid = 1'b1; req_size = SZ_WORD; end
            default: ;
        endcase
    end

    // Naturally aligned lane offset, store byte enables and replicated store data.
    always_comb begin
        req_off   = 2'b00;
        req_be    = 4'b1111;
        req_wdata = WRITE_DATA;
        case (req_size)
            SZ_BYTE: begin
                req_off   = ADDRESS[1:0];
                req_wdata = {4{WRITE_DATA[7:0]}};
                if (!req_load) req_be = 4'b0001 << ADDRESS[1:0];
            end
            SZ_HALF: begin
                req_off   = {ADDRESS[1], 1'b0};
                req_wdata = {2{WRITE_DATA[15:0]}};
                if (!req_load) req_be = ADDRESS[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Flag halfword/word requests whose low address bits break natural alignment.
    always_comb begin
        req_trap = 1'b0;
        if (req_valid) begin
            if (req_size == SZ_HALF)      req_trap = ADDRESS[0];
            else if (req_size == SZ_WORD) req_trap = (ADDRESS[1:0] != 2'b00);
        end
    end
`else
    assign req_trap = 1'b0;
`endif

    // Extract the addressed lane from the returned word and extend it.
    always_comb begin
        byte_sel   = MEM_READDATA[{op_off, 3'b000} +: 8];
        half_sel   = op_off[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
        load_value = MEM_READDATA;
        case (op_size)
            SZ_BYTE: load_value = {{24{op_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_value = {{16{op_signed & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; MEM_READY has priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_trap ? DONE : ACCESS;
            ACCESS:  if (MEM_READY || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side registers, wait counter and load result.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            MEM_BYTEEN    <= 4'b0000;
            READ_DATA     <= '0;
            BUS_ERROR     <= 1'b0;
            wait_cnt      <= '0;
            op_load       <= 1'b0;
            op_signed     <= 1'b0;
            op_size       <= SZ_WORD;
            op_off        <= 2'b00;
        end else begin
            BUS_ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !req_trap) begin
                        MEM_READ      <= req_load;
                        MEM_WRITE     <= !req_load;
                        MEM_ADDRESS   <= ADDRESS[31:2];
                        MEM_WRITEDATA <= req_wdata;
                        MEM_BYTEEN    <= req_be;
                        wait_cnt      <= '0;
                        op_load       <= req_load;
                        op_signed     <= req_signed;
                        op_size       <= req_size;
                        op_off        <= req_off;
                    end else if (req_valid && req_trap) begin
                        READ_DATA <= '0;
                    end
                end
                ACCESS: begin
                    if (MEM_READY) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        if (op_load) READ_DATA <= load_value;
                    end else if (timeout_hit) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        READ_DATA <= '0;
                        BUS_ERROR <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // One-cycle misalignment pulse, visible during the DONE cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) MISALIGNED <= 1'b0;
        else        MISALIGNED <= (state == IDLE) && req_valid && req_trap;
    end
`else
    assign MISALIGNED = 1'b0;
`endif

    // Stall while a request is pending (except in DONE) or memory is busy.
    assign BUSYWAIT  = RESET && ((req_valid && (state != DONE)) || (state == ACCESS));
    assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: a vector table of single accesses
// followed by hand-written timeout, misalignment, idle and reset sequences.
module tb_data_mem_access_unit;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LB  = 4'b1000;
    localparam logic [3:0] OP_LH  = 4'b1001;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_LBU = 4'b1100;
    localparam logic [3:0] OP_LHU = 4'b1101;
    localparam logic [3:0] OP_SB  = 4'b0001;
    localparam logic [3:0] OP_SH  = 4'b0010;
    localparam logic [3:0] OP_SW  = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  read_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busywait;
    logic        misaligned;
    logic        bus_error;
    logic        mem_read;
    logic        mem_write;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_readdata;
    logic        mem_ready;
    logic [1:0]  fsm_state;

    int tests  = 0;
    int failed = 0;

    // Observations gathered by run_access.
    int          busy_cnt;
    int          berr_cnt;
    int          mis_cnt;
    logic        rd_seen;
    logic        wr_seen;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [29:0] ma_seen;
    logic        busy_at_done;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          waits;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [29:0] exp_ma;
        int          exp_busy;
    } vec_t;

    vec_t vecs[11];

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .READ_WRITE    (read_write),
        .ADDRESS       (address),
        .WRITE_DATA    (write_data),
        .READ_DATA     (read_data),
        .BUSYWAIT      (busywait),
        .MISALIGNED    (misaligned),
        .BUS_ERROR     (bus_error),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_address),
        .MEM_WRITEDATA (mem_writedata),
        .MEM_BYTEEN    (mem_byteen),
        .MEM_READDATA  (mem_readdata),
        .MEM_READY     (mem_ready),
        .fsm_state     (fsm_state)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive one request from IDLE, act as memory with 'waits' wait cycles,
    // and return one cycle after DONE with the request removed.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] mword,
                              input int waits);
        int w;
        int guard;
        bit done;
        busy_cnt = 0; berr_cnt = 0; mis_cnt = 0;
        rd_seen = 1'b0; wr_seen = 1'b0; be_seen = '0; wd_seen = '0; ma_seen = '0;
        busy_at_done = 1'b0;
        read_write = op; address = addr; write_data = wd;
        mem_readdata = mword; mem_ready = 1'b0;
        w = 0; guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
            if (busywait)   busy_cnt++;
            if (bus_error)  berr_cnt++;
            if (misaligned) mis_cnt++;
            if (mem_read || mem_write) begin
                rd_seen = rd_seen | mem_read;
                wr_seen = wr_seen | mem_write;
                be_seen = mem_byteen;
                wd_seen = mem_writedata;
                ma_seen = mem_address;
            end
            if (fsm_state == ST_ACCESS) begin
                if (w >= waits) mem_ready = 1'b1;
                else begin mem_ready = 1'b0; w++; end
            end else begin
                mem_ready = 1'b0;
            end
            if (fsm_state == ST_DONE) begin
                busy_at_done = busywait;
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL access_bound: got no DONE within 200 cycles required DONE");
        end
        @(posedge clk);
        #1;
        read_write = OP_NOP;
        mem_ready  = 1'b0;
    endtask

    initial begin
        // Vector table: op, addr, wdata, memory word, waits, READ_DATA after,
        // byte enables, store data, word address, BUSYWAIT cycles.
        vecs[0]  = '{OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 30'h040, 4};
        vecs[1]  = '{OP_LW,  32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,         30'h040, 2};
        vecs[2]  = '{OP_LB,  32'h0000_0201, 32'h0000_0000, 32'h80FF_7F01, 1, 32'h0000_007F, 4'b1111, 32'h0,         30'h080, 3};
        vecs[3]  = '{OP_LB,  32'h0000_0202, 32'h0000_0000, 32'h80FF_7F01, 0, 32'hFFFF_FFFF, 4'b1111, 32'h0,         30'h080, 2};
        vecs[4]  = '{OP_LBU, 32'h0000_0203, 32'h0000_0000, 32'h80FF_7F01, 3, 32'h0000_0080, 4'b1111, 32'h0,         30'h080, 5};
        vecs[5]  = '{OP_SH,  32'h0000_0302, 32'h1234_ABCD, 32'h0000_0000, 0, 32'h0000_0080, 4'b1100, 32'hABCD_ABCD, 30'h0C0, 2};
        vecs[6]  = '{OP_SB,  32'h0000_0011, 32'h1234_56A5, 32'h0000_0000, 1, 32'h0000_0080, 4'b0010, 32'hA5A5_A5A5, 30'h004, 3};
        vecs[7]  = '{OP_LH,  32'h0000_0400, 32'h0000_0000, 32'h8001_FFFE, 0, 32'hFFFF_FFFE, 4'b1111, 32'h0,         30'h100, 2};
        vecs[8]  = '{OP_LHU, 32'h0000_0402, 32'h0000_0000, 32'h8001_FFFE, 0, 32'h0000_8001, 4'b1111, 32'h0,         30'h100, 2};
        vecs[9]  = '{OP_LH,  32'h0000_0402, 32'h0000_0000, 32'h8001_FFFE, 2, 32'hFFFF_8001, 4'b1111, 32'h0,         30'h100, 4};
        vecs[10] = '{OP_SW,  32'h0000_07FC, 32'h0BAD_F00D, 32'h0000_0000, 0, 32'hFFFF_8001, 4'b1111, 32'h0BAD_F00D, 30'h1FF, 2};

        // Reset: all outputs low, FSM idle.
        rst_n = 1'b0; read_write = OP_NOP; address = '0; write_data = '0;
        mem_readdata = '0; mem_ready = 1'b0;
        #1;
        check("reset_read_data",  read_data,              32'h0);
        check("reset_busywait",   {31'b0, busywait},      32'h0);
        check("reset_strobes",    {30'b0, mem_read, mem_write}, 32'h0);
        check("reset_byteen",     {28'b0, mem_byteen},    32'h0);
        check("reset_flags",      {30'b0, misaligned, bus_error}, 32'h0);
        check("reset_mem_addr",   {2'b0, mem_address},    32'h0);
        check("reset_mem_wdata",  mem_writedata,          32'h0);
        check("reset_state",      {30'b0, fsm_state},     {30'b0, ST_IDLE});
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // No request: zero stall, no strobes.
        for (int i = 0; i < 3; i++) begin
            read_write = (i == 1) ? 4'b1111 : OP_NOP;
            @(negedge clk);
            check($sformatf("idle_%0d_busy", i),   {31'b0, busywait}, 32'h0);
            check($sformatf("idle_%0d_strobe", i), {30'b0, mem_read, mem_write}, 32'h0);
        end
        read_write = OP_NOP;
        @(posedge clk); #1;

        // Table-driven single accesses.
        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mword, vecs[i].waits);
            check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
            check($sformatf("vec%0d_mem_addr", i), {2'b0, ma_seen}, {2'b0, vecs[i].exp_ma});
            check($sformatf("vec%0d_byteen", i), {28'b0, be_seen}, {28'b0, vecs[i].exp_be});
            check($sformatf("vec%0d_rd_strobe", i), {31'b0, rd_seen}, {31'b0, vecs[i].op[3]});
            check($sformatf("vec%0d_wr_strobe", i), {31'b0, wr_seen}, {31'b0, ~vecs[i].op[3]});
            check($sformatf("vec%0d_bus_error", i), berr_cnt, 0);
            check($sformatf("vec%0d_busy_at_done", i), {31'b0, busy_at_done}, 32'h0);
            if (!vecs[i].op[3])
                check($sformatf("vec%0d_wdata", i), wd_seen, vecs[i].exp_wd);
        end

        // Timeout: memory never ready, TIMEOUT_CYCLES = 4.
        run_access(OP_LW, 32'h0000_0500, 32'h0, 32'h5555_5555, 1000);
        check("timeout_bus_error_pulses", berr_cnt, 1);
        check("timeout_read_data",        read_data, 32'h0);
        check("timeout_busy_cycles",      busy_cnt, 5);
        check("timeout_busy_at_done",     {31'b0, busy_at_done}, 32'h0);
        @(negedge clk);
        check("timeout_bus_error_clear",  {31'b0, bus_error}, 32'h0);
        check("timeout_back_idle",        {30'b0, fsm_state}, {30'b0, ST_IDLE});
        check("timeout_busy_after",       {31'b0, busywait}, 32'h0);
        @(posedge clk); #1;

        // Misaligned LW at 0x102.
        run_access(OP_LW, 32'h0000_0102, 32'h0, 32'h1122_3344, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign_pulse",     mis_cnt, 1);
        check("misalign_no_read",   {31'b0, rd_seen}, 32'h0);
        check("misalign_busy",      busy_cnt, 1);
        check("misalign_read_data", read_data, 32'h0);
`else
        check("misalign_no_pulse",  mis_cnt, 0);
        check("misalign_read",      {31'b0, rd_seen}, 32'h1);
        check("misalign_word_addr", {2'b0, ma_seen}, 32'h40);
        check("misalign_busy",      busy_cnt, 2);
        check("misalign_read_data", read_data, 32'h1122_3344);
`endif
        @(negedge clk);
        check("misalign_flag_clear", {31'b0, misaligned}, 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of an access.
        run_access(OP_LW, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0);
        check("pre_reset_read_data", read_data, 32'hCAFE_F00D);
        read_write = OP_LW; address = 32'h0000_0100; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_in_access", {30'b0, fsm_state}, {30'b0, ST_ACCESS});
        check("midreset_read_high", {31'b0, mem_read},  32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_mem_read",  {31'b0, mem_read},  32'h0);
        check("midreset_busywait",  {31'b0, busywait},  32'h0);
        check("midreset_read_data", read_data,          32'h0);
        check("midreset_state",     {30'b0, fsm_state}, {30'b0, ST_IDLE});
        read_write = OP_NOP;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_state",    {30'b0, fsm_state}, {30'b0, ST_IDLE});
        check("post_reset_busywait", {31'b0, busywait},  32'h0);
        check("post_reset_strobes",  {30'b0, mem_read, mem_write}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
